// File: rtl/uart_rx.sv
// UART receiver: 2-flop synced line, mid-bit sampling, LSB-first DW-bit frames with one stop bit.
// Strobes land one cycle after the stop sample; no backpressure, rx_data holds until the next good frame.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          rx,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          rx_frame_err,
  output logic          rx_busy
);

  localparam int BAUD_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BAUD_COUNT / 2;
  localparam int CW         = $clog2(BAUD_COUNT);
  localparam int BW         = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_COUNT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shift;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;

  // Synchronizer and edge-detect flops reset to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          // Falling edge only: a line parked low (break) cannot retrigger.
          if (!rx_s && rx_s_d) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shift   <= (shift >> 1) | (DW'(rx_s) << (DW - 1));
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          // Leave at mid stop bit so a zero-gap next start edge is still seen.
          if (cnt == BIT_END) begin
            cnt          <= '0;
            state        <= IDLE;
            rx_busy      <= 1'b0;
            rx_valid     <= rx_s;
            rx_frame_err <= !rx_s;
            if (rx_s) begin
              rx_data <= shift;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          bit_cnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: vector table, hand-built corner sequences, random frames vs a frame-level model.
module tb_uart_rx;

  localparam int BC   = 16;
  localparam int HALF = 8;
  localparam int DW   = 8;
  // Cycles from driving the start edge on the pin to the strobe being visible.
  localparam int LAT  = 3 + HALF + (DW + 1) * BC;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DW(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  ev_t  evq[$];
  ev_t  expq[$];
  int   both_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_good;

  always @(negedge clk) begin
    if (rx_valid || rx_frame_err) begin
      evq.push_back('{rx_frame_err, rx_data, cyc});
      if (rx_valid && rx_frame_err) both_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, output int s);
    s  = cyc;
    rx = 1'b0;
    wait_cyc(BC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BC);
    end
    rx = stop;
    wait_cyc(BC);
  endtask

  // Frame-level model: a good stop bit delivers the word, a bad one flags and keeps the old word.
  task automatic send_model(input logic [7:0] d, input logic stop);
    int s;
    send(d, stop, s);
    if (stop) begin
      expq.push_back('{1'b0, d, s + LAT});
      last_good = d;
    end else begin
      expq.push_back('{1'b1, last_good, s + LAT});
    end
  endtask

  task automatic drain(input string name);
    int n;
    check({name, "_count"}, evq.size(), expq.size());
    n = (evq.size() < expq.size()) ? evq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      check({name, "_kind"}, int'(evq[i].err), int'(expq[i].err));
      check({name, "_data"}, int'(evq[i].data), int'(expq[i].data));
      check({name, "_cycle"}, evq[i].cyc, expq[i].cyc);
    end
    check({name, "_both_strobes"}, both_cnt, 0);
    evq.delete();
    expq.delete();
  endtask

  vec_t vt[8];

  initial begin
    int s;
    int busy_cnt;
    int gap;
    logic [7:0] d;
    logic stp;

    vt[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5};
    vt[1] = '{8'h00, 1'b1, 2, 1'b0, 8'h00};
    vt[2] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};
    vt[3] = '{8'h01, 1'b1, 2, 1'b0, 8'h01};
    vt[4] = '{8'h80, 1'b1, 2, 1'b0, 8'h80};
    vt[5] = '{8'h3C, 1'b1, 0, 1'b0, 8'h3C};
    vt[6] = '{8'hC3, 1'b1, 2, 1'b0, 8'hC3};
    vt[7] = '{8'h5A, 1'b0, 1, 1'b1, 8'hC3};

    // Reset with a toggling line
    last_good = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
    end
    check("reset_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_err", int'(rx_frame_err), 0);
    check("reset_busy", int'(rx_busy), 0);
    rx = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check("post_reset_busy", busy_cnt, 0);
    evq.delete();

    // Table of frames, including a zero-gap pair and a bad stop bit
    for (int i = 0; i < 8; i++) begin
      send(vt[i].data, vt[i].stop, s);
      expq.push_back('{vt[i].exp_err, vt[i].exp_data, s + LAT});
      rx = 1'b1;
      wait_cyc(vt[i].gap * BC);
    end
    wait_cyc(20);
    if (evq.size() >= 7) check("b2b_spacing", evq[6].cyc - evq[5].cyc, 10 * BC);
    else check("b2b_event_count", evq.size(), 7);
    drain("table");
    last_good = 8'hC3;
    check("table_data_hold", int'(rx_data), 8'hC3);

    // Short glitch must abort in START without strobes
    rx = 1'b0;
    wait_cyc(4);
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_bounded", int'(busy_cnt <= HALF + 1), 1);
    check("glitch_busy_seen", int'(busy_cnt > 0), 1);
    drain("glitch");
    check("glitch_data_hold", int'(rx_data), int'(last_good));

    // Framing error followed by a long break
    send_model(8'h5A, 1'b0);
    wait_cyc(40 * BC);
    rx = 1'b1;
    wait_cyc(2 * BC);
    send_model(8'h11, 1'b1);
    rx = 1'b1;
    wait_cyc(20);
    drain("break");
    check("break_data", int'(rx_data), 8'h11);

    // Reset during data bit 3
    d  = 8'h96;
    rx = 1'b0;
    wait_cyc(BC);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wait_cyc(BC);
    end
    rx = d[3];
    wait_cyc(8);
    check("midframe_busy", int'(rx_busy), 1);
    rst_n = 1'b0;
    wait_cyc(1);
    check("midreset_data", int'(rx_data), 0);
    check("midreset_valid", int'(rx_valid), 0);
    check("midreset_err", int'(rx_frame_err), 0);
    check("midreset_busy", int'(rx_busy), 0);
    rx = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    last_good = 8'h00;
    wait_cyc(2 * BC);
    send_model(8'h96, 1'b1);
    rx = 1'b1;
    wait_cyc(20);
    drain("midreset");
    check("midreset_recover_data", int'(rx_data), 8'h96);

    // Random frames with random gaps and occasional bad stop bits
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      send_model(d, stp);
      gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 2);
      rx  = 1'b1;
      wait_cyc(gap * BC);
    end
    wait_cyc(20);
    drain("random");
    check("random_data_hold", int'(rx_data), int'(last_good));
    check("random_idle_busy", int'(rx_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
